// File: rtl/fft_ctrl_pkg.sv
// Shared types and helpers for the radix-2 DIT FFT controller: phase encoding,
// bit reversal and butterfly address/twiddle arithmetic.
package fft_ctrl_pkg;

  localparam int MAX_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_UNLOAD  = 3'd4
  } state_e;

  typedef logic [MAX_BITS-1:0] addr_t;

  typedef struct packed {
    addr_t a;
    addr_t b;
    addr_t tw;
  } bf_addr_t;

  // Reverse the low 'bits' bits of v; bits above 'bits' come back as zero.
  function automatic addr_t bit_rev(input addr_t v, input int bits);
    addr_t src;
    addr_t res;
    src = v;
    res = '0;
    for (int i = 0; i < MAX_BITS; i++) begin
      if (i < bits) begin
        res = {res[MAX_BITS-2:0], src[0]};
        src = {1'b0, src[MAX_BITS-1:1]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic bf_addr_t bf_addr(input addr_t stage, input addr_t j, input int bits);
    addr_t    half;
    addr_t    pos;
    bf_addr_t r;
    half = addr_t'(1) << stage;
    pos  = j & (half - addr_t'(1));
    r.a  = ((j >> stage) << (stage + addr_t'(1))) | pos;
    r.b  = r.a | half;
    r.tw = pos << (bits - 1 - int'(stage));
    return r;
  endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Combinational butterfly operand address and twiddle index generator for one
// (stage, j) pair.
module fft_bf_addr_gen
  import fft_ctrl_pkg::*;
#(
  parameter int BITS_PER_ROW = 3
) (
  input  logic [BITS_PER_ROW-1:0] stage_i,
  input  logic [BITS_PER_ROW-2:0] j_i,
  output logic [BITS_PER_ROW-1:0] a_o,
  output logic [BITS_PER_ROW-1:0] b_o,
  output logic [BITS_PER_ROW-2:0] tw_o
);

  bf_addr_t bf_s;
  logic     unused_s;

  assign bf_s = bf_addr(addr_t'(stage_i), addr_t'(j_i), BITS_PER_ROW);
  assign a_o  = bf_s.a[BITS_PER_ROW-1:0];
  assign b_o  = bf_s.b[BITS_PER_ROW-1:0];
  assign tw_o = bf_s.tw[BITS_PER_ROW-2:0];
  // Upper bits of the package-width result are zero for legal stage/j values.
  assign unused_s = ^bf_s;

endmodule

// File: rtl/fft_stage_sequencer.sv
// Phase sequencer for the in-place radix-2 DIT FFT over a two-bank ping-pong
// memory: bit-reversed load, log2(N) butterfly stages, natural-order unload.
module fft_stage_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int N            = 8,
  parameter int BITS_PER_ROW = 3,
  parameter int BF_LAT       = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    in_valid_i,
  input  logic                    out_ready_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    load_we_o,
  output logic [BITS_PER_ROW-1:0] load_addr_o,
  output logic [BITS_PER_ROW-1:0] stage_o,
  output logic                    rd_en_o,
  output logic                    rd_bank_o,
  output logic [BITS_PER_ROW-1:0] rd_addr_a_o,
  output logic [BITS_PER_ROW-1:0] rd_addr_b_o,
  output logic [BITS_PER_ROW-2:0] tw_idx_o,
  output logic                    wr_en_o,
  output logic                    wr_bank_o,
  output logic [BITS_PER_ROW-1:0] wr_addr_a_o,
  output logic [BITS_PER_ROW-1:0] wr_addr_b_o,
  output logic                    out_rd_en_o,
  output logic                    out_bank_o,
  output logic [BITS_PER_ROW-1:0] out_addr_o
);

  localparam int B  = BITS_PER_ROW;
  localparam int CW = ($clog2(BF_LAT + 1) > B) ? $clog2(BF_LAT + 1) : B;
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(N - 1);
  localparam logic [CW-1:0] LAST_BF     = CW'(N / 2 - 1);
  localparam logic [CW-1:0] LAST_DRAIN  = CW'(BF_LAT - 1);
  localparam logic [B-1:0]  LAST_STAGE  = B'(B - 1);
  localparam logic          OUT_BANK    = 1'(B % 2);

  typedef struct packed {
    logic         v;
    logic [B-1:0] a;
    logic [B-1:0] b;
    logic         bank;
  } wb_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [B-1:0]  stage_q, stage_d;
  addr_t         load_rev_s;
  logic [B-1:0]  bf_a_s, bf_b_s;
  logic [B-2:0]  bf_tw_s;
  wb_t           wb_in_s;
  wb_t           wb_q [BF_LAT];
  logic          unused_s;

  fft_bf_addr_gen #(.BITS_PER_ROW(B)) u_addr_gen (
    .stage_i (stage_q),
    .j_i     (cnt_q[B-2:0]),
    .a_o     (bf_a_s),
    .b_o     (bf_b_s),
    .tw_o    (bf_tw_s)
  );

  assign load_rev_s = bit_rev(addr_t'(cnt_q), B);
  assign unused_s   = ^load_rev_s;
  assign stage_o    = stage_q;

  // Phase, shared phase counter and stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
    end
  end

  // Phase transitions; the counter returns to zero on every phase exit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_LOAD;
        else         state_d = ST_IDLE;
      end
      ST_LOAD: begin
        if (in_valid_i) begin
          if (cnt_q == LAST_SAMPLE) begin
            state_d = ST_COMPUTE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_COMPUTE: begin
        if (cnt_q == LAST_BF) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == LAST_DRAIN) begin
          cnt_d = '0;
          if (stage_q == LAST_STAGE) begin
            state_d = ST_UNLOAD;
            stage_d = '0;
          end else begin
            state_d = ST_COMPUTE;
            stage_d = stage_q + B'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_UNLOAD: begin
        if (out_ready_i) begin
          if (cnt_q == LAST_SAMPLE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        stage_d = '0;
      end
    endcase
  end

  // Output decode from registered phase; only the handshake strobes see inputs.
  always_comb begin
    busy_o      = 1'b0;
    load_we_o   = 1'b0;
    load_addr_o = '0;
    rd_en_o     = 1'b0;
    rd_bank_o   = 1'b0;
    rd_addr_a_o = '0;
    rd_addr_b_o = '0;
    tw_idx_o    = '0;
    out_rd_en_o = 1'b0;
    out_bank_o  = 1'b0;
    out_addr_o  = '0;
    done_o      = 1'b0;
    case (state_q)
      ST_IDLE: busy_o = 1'b0;
      ST_LOAD: begin
        busy_o      = 1'b1;
        load_we_o   = in_valid_i;
        load_addr_o = load_rev_s[B-1:0];
      end
      ST_COMPUTE: begin
        busy_o      = 1'b1;
        rd_en_o     = 1'b1;
        rd_bank_o   = stage_q[0];
        rd_addr_a_o = bf_a_s;
        rd_addr_b_o = bf_b_s;
        tw_idx_o    = bf_tw_s;
      end
      ST_DRAIN: busy_o = 1'b1;
      ST_UNLOAD: begin
        busy_o      = 1'b1;
        out_rd_en_o = out_ready_i;
        out_bank_o  = OUT_BANK;
        out_addr_o  = cnt_q[B-1:0];
        // done is qualified by the accept strobe so it marks the last read itself.
        done_o      = out_ready_i && (cnt_q == LAST_SAMPLE);
      end
      default: busy_o = 1'b0;
    endcase
  end

  assign wb_in_s = '{v: rd_en_o, a: rd_addr_a_o, b: rd_addr_b_o, bank: rd_en_o & ~stage_q[0]};

  // Write-back delay line matching the butterfly pipeline; free-running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BF_LAT; i++) wb_q[i] <= '0;
    end else begin
      wb_q[0] <= wb_in_s;
      for (int i = 1; i < BF_LAT; i++) wb_q[i] <= wb_q[i-1];
    end
  end

  assign wr_en_o     = wb_q[BF_LAT-1].v;
  assign wr_bank_o   = wb_q[BF_LAT-1].bank;
  assign wr_addr_a_o = wb_q[BF_LAT-1].a;
  assign wr_addr_b_o = wb_q[BF_LAT-1].b;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Randomized handshake bench for fft_stage_sequencer at N=8 and N=16 against a
// cycle-level behavioural model of the load/compute/drain/unload schedule.
module tb_fft_stage_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic sel;
  logic start, in_valid, out_ready;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  typedef struct { int due; int a; int b; int bank; } wr_t;
  wr_t wq[$];

  always #5 clk = ~clk;

  logic st8, iv8, or8, st16, iv16, or16;
  assign st8  = start & ~sel;
  assign iv8  = in_valid & ~sel;
  assign or8  = out_ready & ~sel;
  assign st16 = start & sel;
  assign iv16 = in_valid & sel;
  assign or16 = out_ready & sel;

  logic busy8, done8, lwe8, rd8, rbk8, wr8, wbk8, ore8, obk8;
  logic [2:0] la8, stg8, ra8, rb8, wa8, wb8, oa8;
  logic [1:0] tw8;
  logic busy16, done16, lwe16, rd16, rbk16, wr16, wbk16, ore16, obk16;
  logic [3:0] la16, stg16, ra16, rb16, wa16, wb16, oa16;
  logic [2:0] tw16;

  fft_stage_sequencer #(.N(8), .BITS_PER_ROW(3), .BF_LAT(2)) d8 (
    .clk(clk), .rst_n(rst_n), .start_i(st8), .in_valid_i(iv8), .out_ready_i(or8),
    .busy_o(busy8), .done_o(done8), .load_we_o(lwe8), .load_addr_o(la8), .stage_o(stg8),
    .rd_en_o(rd8), .rd_bank_o(rbk8), .rd_addr_a_o(ra8), .rd_addr_b_o(rb8), .tw_idx_o(tw8),
    .wr_en_o(wr8), .wr_bank_o(wbk8), .wr_addr_a_o(wa8), .wr_addr_b_o(wb8),
    .out_rd_en_o(ore8), .out_bank_o(obk8), .out_addr_o(oa8));

  fft_stage_sequencer #(.N(16), .BITS_PER_ROW(4), .BF_LAT(2)) d16 (
    .clk(clk), .rst_n(rst_n), .start_i(st16), .in_valid_i(iv16), .out_ready_i(or16),
    .busy_o(busy16), .done_o(done16), .load_we_o(lwe16), .load_addr_o(la16), .stage_o(stg16),
    .rd_en_o(rd16), .rd_bank_o(rbk16), .rd_addr_a_o(ra16), .rd_addr_b_o(rb16), .tw_idx_o(tw16),
    .wr_en_o(wr16), .wr_bank_o(wbk16), .wr_addr_a_o(wa16), .wr_addr_b_o(wb16),
    .out_rd_en_o(ore16), .out_bank_o(obk16), .out_addr_o(oa16));

  logic o_busy, o_done, o_lwe, o_rd, o_rbk, o_wr, o_wbk, o_ore, o_obk;
  logic [3:0] o_la, o_stg, o_ra, o_rb, o_wa, o_wb, o_oa;
  logic [2:0] o_tw;
  logic [39:0] o_all;
  assign o_busy = sel ? busy16 : busy8;
  assign o_done = sel ? done16 : done8;
  assign o_lwe  = sel ? lwe16  : lwe8;
  assign o_rd   = sel ? rd16   : rd8;
  assign o_rbk  = sel ? rbk16  : rbk8;
  assign o_wr   = sel ? wr16   : wr8;
  assign o_wbk  = sel ? wbk16  : wbk8;
  assign o_ore  = sel ? ore16  : ore8;
  assign o_obk  = sel ? obk16  : obk8;
  assign o_la   = sel ? la16   : {1'b0, la8};
  assign o_stg  = sel ? stg16  : {1'b0, stg8};
  assign o_ra   = sel ? ra16   : {1'b0, ra8};
  assign o_rb   = sel ? rb16   : {1'b0, rb8};
  assign o_wa   = sel ? wa16   : {1'b0, wa8};
  assign o_wb   = sel ? wb16   : {1'b0, wb8};
  assign o_oa   = sel ? oa16   : {1'b0, oa8};
  assign o_tw   = sel ? tw16   : {1'b0, tw8};
  assign o_all  = {o_busy, o_done, o_lwe, o_la, o_stg, o_rd, o_rbk, o_ra, o_rb, o_tw,
                   o_wr, o_wbk, o_wa, o_wb, o_ore, o_obk, o_oa};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic settle();
    #3;
  endtask

  function automatic int brev(input int v, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++)
      if ((v >> i) % 2 == 1) r += 1 << (bits - 1 - i);
    return r;
  endfunction

  task automatic check_wr();
    if (wq.size() > 0 && wq[0].due == cyc) begin
      check("wr_en", o_wr, 1);
      check("wr_addr_a", o_wa, wq[0].a);
      check("wr_addr_b", o_wb, wq[0].b);
      check("wr_bank", o_wbk, wq[0].bank);
      wq.delete(0);
    end else begin
      check("wr_en_quiet", o_wr, 0);
    end
  endtask

  // One transform on the selected instance; cont forces every handshake high,
  // abort pulls reset at stage 1, j = 2.
  task automatic run(input bit big, input bit cont, input bit abort);
    int n, bits, k, t0, half, pos, a;
    bit iv, rr;
    n = big ? 16 : 8;
    bits = big ? 4 : 3;
    sel = big;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    settle();
    check("idle_busy", o_busy, 0);
    t0 = cyc;
    tick();
    k = 0;
    while (k < n) begin
      iv = cont || ($urandom_range(0, 2) != 0);
      in_valid = iv;
      out_ready = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      settle();
      check("load_busy", o_busy, 1);
      check("load_we", o_lwe, iv);
      check("load_addr", o_la, brev(k, bits));
      check("load_no_out", o_ore, 0);
      check("load_no_rd", o_rd, 0);
      if (iv) k++;
      tick();
    end
    for (int s = 0; s < bits; s++) begin
      half = 1 << s;
      for (int j = 0; j < n / 2; j++) begin
        in_valid = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        settle();
        pos = j % half;
        a = (j / half) * 2 * half + pos;
        check("rd_en", o_rd, 1);
        check("stage", o_stg, s);
        check("rd_bank", o_rbk, s % 2);
        check("rd_addr_a", o_ra, a);
        check("rd_addr_b", o_rb, a + half);
        check("tw_idx", o_tw, pos << (bits - 1 - s));
        check("comp_no_load", o_lwe, 0);
        check("comp_no_out", o_ore, 0);
        check_wr();
        if (abort && s == 1 && j == 2) begin
          rst_n = 1'b0;
          #1;
          check("abort_all_zero", {31'd0, |o_all}, 0);
          wq.delete();
          return;
        end
        wq.push_back('{cyc + 2, a, a + half, (s % 2) ^ 1});
        tick();
      end
      for (int d = 0; d < 2; d++) begin
        settle();
        check("drain_rd_en", o_rd, 0);
        check("drain_stage", o_stg, s);
        check("drain_busy", o_busy, 1);
        check_wr();
        tick();
      end
    end
    start = 1'b0; in_valid = 1'b0;
    k = 0;
    while (k < n) begin
      rr = cont || ($urandom_range(0, 1) == 1);
      out_ready = rr;
      settle();
      check("out_rd_en", o_ore, rr);
      check("out_addr", o_oa, k);
      check("out_bank", o_obk, bits % 2);
      check("done", o_done, rr && (k == n - 1));
      check("unload_busy", o_busy, 1);
      check_wr();
      if (cont && rr && k == n - 1) check("latency", cyc - t0, n + bits * (n / 2 + 2) + n);
      if (rr) k++;
      tick();
    end
    out_ready = 1'b0;
    settle();
    check("end_busy", o_busy, 0);
    check("end_done", o_done, 0);
    tick();
  endtask

  initial begin
    sel = 1'b0; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1; rst_n = 1'b0;
    tick();
    tick();
    settle();
    check("reset_zero_n8", {31'd0, |o_all}, 0);
    sel = 1'b1;
    #1;
    check("reset_zero_n16", {31'd0, |o_all}, 0);
    tick();
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b1; out_ready = 1'b1; sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("post_reset_idle", o_busy, 0);
      check("post_reset_no_we", o_lwe, 0);
      check("post_reset_no_out", o_ore, 0);
      tick();
    end
    run(1'b0, 1'b0, 1'b0);
    run(1'b0, 1'b1, 1'b0);
    run(1'b0, 1'b0, 1'b1);
    tick();
    tick();
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("abort_no_wr", o_wr, 0);
      check("abort_idle", o_busy, 0);
      tick();
    end
    run(1'b0, 1'b1, 1'b0);
    run(1'b1, 1'b0, 1'b0);
    run(1'b1, 1'b1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
